// File: rtl/vm80a_intc.sv
// Prioritised interrupt controller with periodic tick timer and RST-n vector generation for vm80a.
// Optional level-sensitive source mode is built when VM80A_INTC_LEVEL_EN is defined.
module vm80a_intc #(
  parameter int NIRQ      = 8,
  parameter int SYS_CLOCK = 50000000,
  parameter int TICK_HZ   = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  input  logic            wr,
  input  logic [2:0]      adr,
  input  logic [7:0]      din,
  output logic [7:0]      dout,
  input  logic [NIRQ-1:0] irq_i,
  input  logic            sync,
  input  logic [7:0]      dstat,
  output logic            int_o,
  output logic            inta_o,
  output logic [7:0]      vec_o
);

  localparam int PDIV = SYS_CLOCK / TICK_HZ;
  localparam int PW   = (PDIV > 1) ? $clog2(PDIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PDIV - 1);

  logic [NIRQ-1:0] mask, pend, mode;
  logic [NIRQ-1:0] s1, s2, s3;
  logic [NIRQ-1:0] edge_det, req, w1c, ack_clr, pend_nx;
  logic [15:0]     rld, cnt;
  logic [7:0]      latch, rd;
  logic [PW-1:0]   pre;
  logic            wr_en, tmr_hi_wr, tick, expiry, capture, hit, inta_nx;
  logic [2:0]      n;
  logic            unused_ok;

  assign unused_ok = ^dstat[7:1];

  assign wr_en     = ce & wr;
  assign tmr_hi_wr = wr_en && (adr == 3'd3);
  assign tick      = (pre == PMAX);
  // A TMR_HI commit in the same clk as a tick swallows that tick.
  assign expiry    = tick & ~tmr_hi_wr & (rld != 16'd0) & (cnt == 16'd1);

  // Timer: free-running prescaler, down-counter reloaded from RLD on expiry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      latch <= '0;
      rld   <= '0;
      cnt   <= '0;
      pre   <= '0;
    end else begin
      if (wr_en && (adr == 3'd2)) latch <= din;
      if (tmr_hi_wr) begin
        rld <= {din, latch};
        cnt <= {din, latch};
        pre <= '0;
      end else begin
        pre <= tick ? '0 : pre + PW'(1);
        if (tick && (rld != 16'd0))
          cnt <= (cnt <= 16'd1) ? rld : cnt - 16'd1;
      end
    end
  end

`ifdef VM80A_INTC_LEVEL_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                      mode <= '0;
    else if (wr_en && (adr == 3'd4)) mode <= din[NIRQ-1:0];
  end
`else
  assign mode = '0;
`endif

  assign edge_det = s2 & ~s3;
  assign req      = pend & mask;
  assign w1c      = (wr_en && (adr == 3'd1)) ? din[NIRQ-1:0] : '0;
  assign capture  = sync & dstat[0] & ~inta_o;
  assign inta_nx  = sync ? dstat[0] : inta_o;

  // Lowest index wins: scan downward so the last hit is the smallest k.
  always_comb begin
    hit = 1'b0;
    n   = 3'd0;
    for (int k = NIRQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        hit = 1'b1;
        n   = 3'(k);
      end
    end
    ack_clr = '0;
    pend_nx = '0;
    for (int k = 0; k < NIRQ; k++) begin
      ack_clr[k] = capture & hit & (n == 3'(k));
      if (mode[k])
        pend_nx[k] = s2[k] | ((k == 0) && expiry);
      else
        pend_nx[k] = (pend[k] & ~w1c[k] & ~ack_clr[k]) | edge_det[k] | ((k == 0) && expiry);
    end
  end

  always_comb begin
    rd = '0;
    case (adr)
      3'd0: rd[NIRQ-1:0] = mask;
      3'd1: rd[NIRQ-1:0] = pend;
      3'd2: rd = rld[7:0];
      3'd3: rd = rld[15:8];
`ifdef VM80A_INTC_LEVEL_EN
      3'd4: rd[NIRQ-1:0] = mode;
`endif
      default: rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask   <= '0;
      pend   <= '0;
      s1     <= '0;
      s2     <= '0;
      s3     <= '0;
      int_o  <= 1'b0;
      inta_o <= 1'b0;
      vec_o  <= 8'hFF;
      dout   <= '0;
    end else begin
      s1   <= irq_i;
      s2   <= s1;
      s3   <= s2;
      pend <= pend_nx;
      if (wr_en && (adr == 3'd0)) mask <= din[NIRQ-1:0];
      if (ce && !wr)              dout <= rd;
      int_o  <= (|req) & ~inta_o;
      inta_o <= inta_nx;
      // Vector latched at INTA entry, held for the cycle, idles at RST 7.
      if (capture)
        vec_o <= hit ? {2'b11, n, 3'b111} : 8'hFF;
      else if (!inta_nx)
        vec_o <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_vm80a_intc.sv
// Directed bench for vm80a_intc: capture, priority, acknowledge, timer, W1C races, reset mid-INTA.
module tb_vm80a_intc;
  logic       clk = 1'b0;
  logic       rst_n, ce, wr, sync, int_o, inta_o;
  logic [2:0] adr;
  logic [7:0] din, dout, irq_i, dstat, vec_o, rv;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  vm80a_intc #(.NIRQ(8), .SYS_CLOCK(100), .TICK_HZ(10)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .wr(wr), .adr(adr), .din(din), .dout(dout),
    .irq_i(irq_i), .sync(sync), .dstat(dstat), .int_o(int_o), .inta_o(inta_o), .vec_o(vec_o)
  );

  task automatic step(input int cnt);
    repeat (cnt) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    ce = 1'b1; wr = 1'b1; adr = a; din = d;
    step(1);
    ce = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [7:0] d);
    ce = 1'b1; wr = 1'b0; adr = a;
    step(1);
    ce = 1'b0;
    d = dout;
  endtask

  task automatic inta_begin();
    sync = 1'b1; dstat = 8'h23;
    step(1);
    sync = 1'b0; dstat = 8'h00;
  endtask

  task automatic inta_end();
    sync = 1'b1; dstat = 8'h02;
    step(1);
    sync = 1'b0; dstat = 8'h00;
  endtask

  task automatic pulse(input logic [7:0] v);
    irq_i = v;
    step(1);
    irq_i = 8'h00;
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b0; wr = 1'b0; adr = '0; din = '0;
    irq_i = '0; sync = 1'b0; dstat = '0;
    step(2);
    chk("rst_int", {7'd0, int_o}, 8'h00);
    chk("rst_inta", {7'd0, inta_o}, 8'h00);
    chk("rst_vec", vec_o, 8'hFF);
    chk("rst_dout", dout, 8'h00);
    rst_n = 1'b1;
    rd_reg(3'd0, rv); chk("rst_mask", rv, 8'h00);

    // Edge capture on source 2 and its acknowledge.
    wr_reg(3'd0, 8'h05);
    pulse(8'h04);
    step(2);
    chk("int_before", {7'd0, int_o}, 8'h00);
    rd_reg(3'd1, rv); chk("pend_src2", rv, 8'h04);
    chk("int_set", {7'd0, int_o}, 8'h01);
    inta_begin();
    chk("inta_hi", {7'd0, inta_o}, 8'h01);
    chk("vec_src2", vec_o, 8'hD7);
    step(1);
    chk("int_drop", {7'd0, int_o}, 8'h00);
    rd_reg(3'd1, rv); chk("pend_ackd", rv, 8'h00);
    chk("vec_frozen", vec_o, 8'hD7);
    inta_end();
    chk("inta_lo", {7'd0, inta_o}, 8'h00);
    chk("vec_idle", vec_o, 8'hFF);
    step(1);
    chk("int_stay0", {7'd0, int_o}, 8'h00);

    // Priority between sources 1 and 3.
    pulse(8'h0A);
    step(3);
    wr_reg(3'd0, 8'hFF);
    inta_begin(); chk("vec_src1", vec_o, 8'hCF);
    inta_end();
    rd_reg(3'd1, rv); chk("pend_after1", rv, 8'h08);
    inta_begin(); chk("vec_src3", vec_o, 8'hDF);
    inta_end();
    rd_reg(3'd1, rv); chk("pend_after3", rv, 8'h00);

    // Spurious acknowledge with everything masked.
    wr_reg(3'd0, 8'h00);
    pulse(8'h02);
    step(3);
    inta_begin();
    chk("spur_inta", {7'd0, inta_o}, 8'h01);
    chk("spur_vec", vec_o, 8'hFF);
    inta_end();
    rd_reg(3'd1, rv); chk("spur_pend", rv, 8'h02);

    // W1C coincident with a new edge on the same bit: set wins.
    irq_i = 8'h02; step(1); irq_i = 8'h00; step(1);
    wr_reg(3'd1, 8'h02);
    rd_reg(3'd1, rv); chk("w1c_race", rv, 8'h02);
    wr_reg(3'd1, 8'h02);
    rd_reg(3'd1, rv); chk("w1c_clear", rv, 8'h00);

    // Timer: RLD=3 ticks of 10 clk -> expiry 30 clk after the TMR_HI commit.
    wr_reg(3'd2, 8'h03);
    wr_reg(3'd3, 8'h00);
    rd_reg(3'd2, rv); chk("rld_lo", rv, 8'h03);
    rd_reg(3'd3, rv); chk("rld_hi", rv, 8'h00);
    step(27);
    rd_reg(3'd1, rv); chk("tmr_pre1", rv, 8'h00);
    rd_reg(3'd1, rv); chk("tmr_exp1", rv, 8'h01);
    wr_reg(3'd1, 8'h01);
    step(27);
    rd_reg(3'd1, rv); chk("tmr_pre2", rv, 8'h00);
    rd_reg(3'd1, rv); chk("tmr_exp2", rv, 8'h01);
    wr_reg(3'd1, 8'h01);
    wr_reg(3'd2, 8'h00);
    wr_reg(3'd3, 8'h00);
    step(80);
    rd_reg(3'd1, rv); chk("tmr_off", rv, 8'h00);

    // Unmapped addresses.
    wr_reg(3'd5, 8'hAA);
    rd_reg(3'd5, rv); chk("adr5", rv, 8'h00);
    rd_reg(3'd4, rv); chk("adr4", rv, 8'h00);

    // Reset in the middle of an INTA cycle.
    wr_reg(3'd0, 8'hFF);
    pulse(8'h04);
    step(3);
    inta_begin();
    chk("pre_rst_vec", vec_o, 8'hD7);
    rst_n = 1'b0;
    step(1);
    chk("rst_inta2", {7'd0, inta_o}, 8'h00);
    chk("rst_vec2", vec_o, 8'hFF);
    chk("rst_int2", {7'd0, int_o}, 8'h00);
    rst_n = 1'b1;
    rd_reg(3'd0, rv); chk("rst_mask2", rv, 8'h00);

`ifdef VM80A_INTC_LEVEL_EN
    // Level-sensitive source 4.
    wr_reg(3'd4, 8'h10);
    wr_reg(3'd0, 8'h10);
    irq_i = 8'h10;
    step(5);
    inta_begin(); chk("lvl_vec", vec_o, 8'hE7);
    inta_end();
    rd_reg(3'd1, rv); chk("lvl_reassert", rv, 8'h10);
    irq_i = 8'h00;
    step(3);
    rd_reg(3'd1, rv); chk("lvl_release", rv, 8'h00);
    rd_reg(3'd4, rv); chk("lvl_mode", rv, 8'h10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vm80a_intc.md
Name: vm80a_intc

Overview:
- Parametrised interrupt controller and periodic timer for vm80a-based systems.
- Replaces the fixed 1 ms single-source interrupt generator with the following:
  - NIRQ prioritised sources, per-source mask and pending bits.
  - A programmable 16-bit tick timer.
  - RST-n vector generation during INTA.
- Sits between board peripherals and the vm80a_core pin_int / pin_din path.
- Is accessed as an 8-bit register file on the system I/O page.

Parameters:
- NIRQ, 8, number of interrupt sources, 1..8; source k maps to RST k.
- SYS_CLOCK, 50000000, clk frequency in Hz.
- TICK_HZ, 1000, timer tick rate; prescaler period is SYS_CLOCK/TICK_HZ clocks.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- ce  in  1  register block select; address decode is done outside this block.
- wr  in  1  write strobe, qualified by ce; one write per clk it is high.
- adr  in  3  register address.
- din  in  8  write data (CPU dout).
- dout  out  8  registered read data.
- irq_i  in  NIRQ  asynchronous request inputs.
- sync  in  1  CPU SYNC.
- dstat  in  8  CPU data bus, carrying the status word during sync.
- int_o  out  1  interrupt request to the CPU.
- inta_o  out  1  interrupt acknowledge cycle active.
- vec_o  out  8  opcode driven to the CPU while inta_o is high.

Behaviour:
- Reset (rst_n low at clk edge):
  - MASK=0, PEND=0, RLD=0, latch=0, cnt=0, prescaler=0, synchronisers=0.
  - int_o=0, inta_o=0, vec_o=8'hFF, dout=0.
  - Reset mid-INTA drops inta_o immediately.
- Register map (adr):
  - 0 MASK, R/W.
  - 1 PEND: R; write 1 clears the bit.
  - 2 TMR_LO: write loads the holding latch; read returns RLD[7:0].
  - 3 TMR_HI: write commits {din, latch} to RLD, loads cnt=RLD, clears the prescaler; read returns RLD[15:8].
  - 4 MODE (optional feature only).
  - 5..7: read 0, writes ignored.
  - Bits >= NIRQ read 0 and are not writable.
- Read timing: dout <= selected register on every clk where ce & ~wr, so data is valid 1 clk after the access. Otherwise dout holds.
- Input capture: each irq_i[k] passes through a 2-FF synchroniser. A rising edge of the synchronised level sets PEND[k]. Latency from irq_i to PEND is 3 clk.
- Timer:
  - Prescaler counts 0..SYS_CLOCK/TICK_HZ-1 and issues a 1-clk tick on wrap.
  - RLD=0 disables the timer: cnt is held and no expiry occurs.
  - On a tick with RLD!=0, cnt decrements. When cnt==1 at a tick, expiry fires and cnt<=RLD.
  - The period is exactly RLD ticks.
  - Expiry sets PEND[0], ORed with the irq_i[0] edge.
- Request: int_o registered, int_o <= |(PEND & MASK) & ~inta_o.
- Acknowledge:
  - On a clk where sync=1, inta_o <= dstat[0], mirroring the CPU status latch.
  - On the clk where inta_o rises (sync & dstat[0] & ~inta_o):
    - n = lowest index with PEND[n]&MASK[n]; index 0 has highest priority.
    - vec_o <= {2'b11, n[2:0], 3'b111}.
    - PEND[n] is cleared.
  - If no masked pending bit exists at capture (spurious acknowledge), vec_o <= 8'hFF (RST 7) and nothing is cleared.
  - vec_o is frozen while inta_o=1. When inta_o falls, vec_o returns to 8'hFF.
- Simultaneous events on the same bit in the same clk:
  - A set (edge or expiry) wins over a write-1-clear or an acknowledge clear.
  - A MASK write takes effect on int_o the next clk.
  - A TMR_HI write coincident with a tick: the commit wins and the tick is discarded.
- Arithmetic: prescaler width = clog2(SYS_CLOCK/TICK_HZ); cnt is 16-bit unsigned with no underflow path.

Optional Feature:
- Macro: VM80A_INTC_LEVEL_EN.
- Enabled:
  - MODE register at adr 4, R/W, reset 0.
  - MODE[k]=1 makes source k level-sensitive: PEND[k] <= synchronised irq_i[k] every clk.
  - While in level mode, W1C and acknowledge clears of bit k have no lasting effect.
  - For source 0 in level mode, timer expiry still sets PEND[0] for one clk.
- Disabled:
  - adr 4 reads 0 and writes are ignored.
  - All sources are edge-triggered.

Test Plan:
- Reset, MASK=8'h05, pulse irq_i[2] for 1 clk wide enough to be sampled -> PEND=8'h04 after 3 clk, int_o=1 next clk. Then sync with dstat=8'h23 -> inta_o=1, vec_o=8'hD7, PEND=0, int_o stays 0.
- PEND bits 1 and 3 set, MASK=8'hFF, INTA cycle -> vec_o=8'hCF, PEND=8'h08. Second INTA -> vec_o=8'hDF, PEND=0.
- SYS_CLOCK=100, TICK_HZ=10, write TMR_LO=8'h03 then TMR_HI=8'h00 -> PEND[0] sets every 30 clk. Write TMR_HI with RLD=0 -> no further expiry.
- INTA with MASK=0 while PEND=8'h02 -> vec_o=8'hFF, PEND unchanged. Write PEND=8'h02 in the same clk as a new irq_i[1] edge -> PEND[1] remains 1.
- rst_n low during inta_o=1 -> next clk: inta_o=0, vec_o=8'hFF, int_o=0, MASK=0.
- With VM80A_INTC_LEVEL_EN: MODE=8'h10, MASK=8'h10, hold irq_i[4] high -> INTA gives vec_o=8'hE7, PEND[4] re-asserts after the acknowledge. Release irq_i[4] -> PEND[4]=0 within 3 clk. Without the macro, read of adr 4 -> dout=8'h00.
